// File: rtl/cpu_defs.sv
// Shared front-end definitions: fetch FSM state encoding, HALT opcode, PC step, reset PC.
package cpu_defs;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [3:0] HALT_OP  = 4'hF;
  localparam int         PC_STEP  = 2;
  localparam logic [7:0] RESET_PC = 8'h00;
endpackage

// File: rtl/fetch_queue.sv
// 2-entry FIFO of {instr, pc}; head is a register, latency 1 push->head.
// Simultaneous push+pop on a full queue keeps occupancy; flush empties it and beats push/pop.
module fetch_queue #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_eff, push_eff;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign head_dat = ent0_q;
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (empty) ent0_d = push_dat;
          else       ent1_d = push_dat;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever survives the pop.
          if (cnt_q == 2'd1) begin
            ent0_d = push_dat;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// Front-end fetch: owns PC, fetches from combinational imem into a 2-entry queue, valid/ready to decode.
// Stalls PC when the queue is full; optional perf counters under FETCH_PERF_EN.
module fetch_controller
  import cpu_defs::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_defs::RESET_PC),
  parameter logic [3:0]      HALT_OP  = cpu_defs::HALT_OP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]        stall_cnt,
  output logic [15:0]        fetch_cnt,
`endif
  output logic               halted
);
  localparam int QW = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, flush, pop;
  logic              q_full, q_empty;
  logic [QW-1:0]     head_dat;
  logic              unused_rpc_lsb;

  assign unused_rpc_lsb = redirect_pc[0];
  assign pop            = out_valid & out_ready;
  assign imem_addr      = pc_q;
  assign out_valid      = ~q_empty;
  assign out_instr      = head_dat[ADDR_W +: INSTR_W];
  assign out_pc         = head_dat[ADDR_W-1:0];
  assign halted         = (state_q == ST_HALT) & q_empty;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = {redirect_pc[ADDR_W-1:1], 1'b0};
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_FETCH;
        ST_FETCH: begin
          if (!q_full || pop) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(PC_STEP);
            if (imem_data[INSTR_W-1 -: 4] == HALT_OP) state_d = ST_HALT;
          end
        end
        ST_HALT:  if (start) state_d = ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(.W(QW)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({imem_data, pc_q}),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_dat),
    .full     (q_full),
    .empty    (q_empty)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] stall_q, fetch_q;
  logic        perf_clr, stall_ev;

  assign perf_clr  = ~redirect_valid & (state_q == ST_IDLE) & start;
  assign stall_ev  = (state_q == ST_FETCH) & q_full & ~pop;
  assign stall_cnt = stall_q;
  assign fetch_cnt = fetch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      fetch_q <= 16'd0;
    end else if (perf_clr) begin
      stall_q <= 16'd0;
      fetch_q <= 16'd0;
    end else begin
      if (stall_ev && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (push && fetch_q != 16'hFFFF)     fetch_q <= fetch_q + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller: expected delivery stream kept in a scoreboard queue.
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst_n, start, redirect_valid, out_ready;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr, out_pc;
  logic [15:0] imem_data, out_instr;
  logic        out_valid, halted;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt, fetch_cnt;
`endif

  logic [15:0] mem [128];
  logic [23:0] sb [$];
  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  logic        rand_rdy = 1'b0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:1]];

  fetch_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
    .stall_cnt      (stall_cnt),
    .fetch_cnt      (fetch_cnt),
`endif
    .halted         (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected stream from a start PC: consecutive words until and including a HALT opcode.
  function automatic void fill(input logic [7:0] p);
    sb.delete();
    for (int i = 0; i < 128; i++) begin
      sb.push_back({mem[p[7:1]], p});
      if (mem[p[7:1]][15:12] == 4'hF) break;
      p = p + 8'd2;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [23:0] exp;
      hs_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got pc=%0h instr=%0h, expected nothing", out_pc, out_instr);
      end else begin
        exp = sb.pop_front();
        if ({out_instr, out_pc} !== exp) begin
          errors++;
          $display("FAIL stream: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                   out_pc, out_instr, exp[7:0], exp[23:8]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    out_ready = 1'b0; rand_rdy = 1'b0;
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] p);
    start = 1'b1;
    tick();
    start = 1'b0;
    fill(p);
  endtask

  task automatic do_redirect(input logic [7:0] p);
    redirect_valid = 1'b1;
    redirect_pc    = p;
    tick();
    redirect_valid = 1'b0;
    fill({p[7:1], 1'b0});
  endtask

  initial begin
    int h0;
    bit done;
    for (int i = 0; i < 128; i++) mem[i] = {4'(i % 15), 12'(i * 37 + 5)};

    // Reset values and start latency, streaming at full rate
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imem_addr", imem_addr, 8'h00);
    out_ready = 1'b1;
    do_start(8'h00);
    chk("latency_no_valid_at_N", out_valid, 0);
    tick();
    chk("latency_valid_at_N1", out_valid, 1);
    chk("first_pc", out_pc, 8'h00);
    h0 = hs_cnt;
    repeat (10) tick();
    chk("throughput", hs_cnt - h0, 10);
    repeat (10) tick();

    // Backpressure fills the queue and holds PC
    do_reset();
    do_start(8'h00);
    repeat (5) tick();
    chk("stall_imem_addr", imem_addr, 8'h04);
    chk("stall_valid", out_valid, 1);
    chk("stall_head_pc", out_pc, 8'h00);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", fetch_cnt, 2);
`endif
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    repeat (3) tick();

    // Redirect on a full queue to an odd target
    do_redirect(8'h21);
    chk("redirect_bubble", out_valid, 0);
    chk("redirect_pc_reg", imem_addr, 8'h20);
    tick();
    chk("redirect_valid_after", out_valid, 1);
    chk("redirect_first_pc", out_pc, 8'h20);
    rand_rdy = 1'b1;
    repeat (40) tick();

    // HALT at 0x10, then resume with start
    do_reset();
    mem[8] = 16'hF0AB;
    do_start(8'h00);
    rand_rdy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (halted) done = 1'b1;
    end
    chk("halt_reached", halted, 1);
    chk("halt_imem_addr", imem_addr, 8'h12);
    chk("halt_sb_drained", sb.size(), 0);
    chk("halt_no_valid", out_valid, 0);
    repeat (5) tick();
    chk("halt_pc_held", imem_addr, 8'h12);
    do_start(8'h12);
    chk("resume_halted_low", halted, 0);
    repeat (40) tick();

    // PC wrap FE -> 00
    do_reset();
    mem[8] = {4'(8 % 15), 12'(8 * 37 + 5)};
    do_redirect(8'hFE);
    tick();
    chk("wrap_first_pc", out_pc, 8'hFE);
    tick();
    out_ready = 1'b1;
    tick();
    chk("wrap_next_valid", out_valid, 1);
    chk("wrap_next_pc", out_pc, 8'h00);
    rand_rdy = 1'b1;
    repeat (20) tick();

    // Asynchronous reset mid-stream, away from a clock edge
    #2;
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_imem_addr", imem_addr, 8'h00);
    chk("arst_halted", halted, 0);
    rand_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("arst_idle_no_fetch", imem_addr, 8'h00);
    chk("arst_idle_no_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
